multi_channel_debouncer: RTL and testbench
==========================================

Name: multi_channel_debouncer

Overview:
Parametrised multi-channel input conditioner for slow external lines such as I2C SCL/SDA, buttons and strap pins. Each channel has a metastability synchroniser, a sample-rate prescaler and a unanimous-vote history filter. It replaces the single-channel fixed-width debouncer in the I2C front end. All channels share one prescaler, so their timing stays aligned.

Parameters:
CHANNELS, 2, number of independent input lines (>=1)
SYNC_STAGES, 2, flip-flops in each synchroniser chain (>=2)
FILTER_WIDTH, 3, consecutive identical samples required to change the output (>=2)
SAMPLE_DIV, 1, control_clock cycles per filter sample tick (>=1)
RESET_LEVEL, 1, value loaded into history and outputs on reset (1 = I2C idle-high)

Ports:
control_clock  input  1  sole clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = filters advance on sample ticks; 0 = filters frozen
raw_in  input  CHANNELS  asynchronous external lines, bit i = channel i
debounced  output  CHANNELS  filtered level per channel, registered
sample_tick  output  1  registered strobe, high for the one clock in which filters shift

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - sync chains = RESET_LEVEL
  - history = all RESET_LEVEL
  - debounced = {CHANNELS{RESET_LEVEL}}
  - prescaler = 0, sample_tick = 0
- Reset asserted mid-transition discards any partial history. There are no glitches on outputs after release.
- Synchroniser:
  - SYNC_STAGES-deep chain per channel, shifting every clock regardless of enable.
  - sync_out[i] is the last stage.
- Prescaler:
  - Counter width = max(1, clog2(SAMPLE_DIV)).
  - When enable = 1: increments each clock; on count == SAMPLE_DIV-1 it wraps to 0 and asserts the internal tick.
  - SAMPLE_DIV = 1 gives a tick every clock.
  - When enable = 0: counter holds its value, no tick.
  - sample_tick output is the internal tick registered (one-clock delayed copy).
- History:
  - FILTER_WIDTH-bit shift register per channel.
  - On tick: history <= {history[FILTER_WIDTH-2:0], sync_out[i]}.
  - Otherwise held.
- Output decision, evaluated every clock independent of tick and enable:
  - history all 1 -> debounced[i] <= 1
  - history all 0 -> debounced[i] <= 0
  - mixed -> hold
- Latency, with enable = 1, SAMPLE_DIV = 1 and raw_in stable after a change: debounced follows after SYNC_STAGES + FILTER_WIDTH + 1 clocks.
  - General worst case: SYNC_STAGES + FILTER_WIDTH*SAMPLE_DIV + 1 clocks.
- Rejection: any pulse shorter than FILTER_WIDTH consecutive samples never changes debounced.
- Channels are fully independent; simultaneous changes on several channels are each filtered identically.
- enable deasserted mid-filter:
  - history and prescaler freeze; debounced holds.
  - Resuming continues from the frozen state without a restart.

Optional Feature:
DEBOUNCE_EDGE_EN
- Defined: adds outputs rise (CHANNELS) and fall (CHANNELS), both registered.
  - rise[i] pulses high for exactly one clock, in the same cycle debounced[i] goes 0->1.
  - fall[i] behaves likewise for 1->0.
  - Both reset to 0.
  - No pulse on reset release even if RESET_LEVEL differs from raw_in; the first settled change produces the pulse.
- Undefined: rise/fall ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset with RESET_LEVEL=1, raw_in=2'b00 held -> debounced=2'b11 during reset; after release debounced=2'b00 exactly 6 clocks later (SYNC=2, W=3, DIV=1).
- Channel 0 glitch low for 2 clocks, channel 1 steady high, DIV=1 -> debounced stays 2'b11 throughout; no fall pulse.
- Channel 0 low for 3+ clocks -> debounced[0]=0 at clock 6 after the edge; fall[0] is a single one-clock pulse (EDGE_EN).
- SAMPLE_DIV=4, step raw_in[1] 1->0 -> sample_tick every 4th clock; debounced[1] falls within 2+12+1 = 15 clocks and not before 2+8+1 = 11 clocks.
- enable=0 mid-transition for 10 clocks, then 1 -> debounced unchanged while low; transition completes using the remaining samples only.
- Assert reset during a partial transition (history 3'b100) -> all outputs return to RESET_LEVEL asynchronously, before the next edge; no rise/fall pulse.

Source files
------------

// File: rtl/multi_channel_debouncer.sv
// Multi-channel synchroniser + shared prescaler + unanimous-vote filter; debounced/sample_tick registered.
// Optional edge pulses (rise/fall) when DEBOUNCE_EDGE_EN is defined; enable=0 freezes filter and prescaler only.
module multi_channel_debouncer #(
    parameter int CHANNELS     = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_WIDTH = 3,
    parameter int SAMPLE_DIV   = 1,
    parameter bit RESET_LEVEL  = 1'b1
) (
    input  logic                control_clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] debounced,
    output logic                sample_tick
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
`endif
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CHANNELS-1:0][SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [CHANNELS-1:0][FILTER_WIDTH-1:0] hist_q, hist_d;
    logic [CHANNELS-1:0]                   debounced_q, debounced_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic                                  tick;
    logic                                  sample_tick_q, sample_tick_d;

    always_comb begin
        tick          = enable && (cnt_q == CNT_LAST);
        sample_tick_d = tick;
        cnt_d         = cnt_q;
        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
        for (int i = 0; i < CHANNELS; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw_in[i]};
            hist_d[i] = tick ? {hist_q[i][FILTER_WIDTH-2:0], sync_q[i][SYNC_STAGES-1]}
                             : hist_q[i];
            // Only a unanimous history may move the output; mixed history holds.
            debounced_d[i] = debounced_q[i];
            if (&hist_q[i]) begin
                debounced_d[i] = 1'b1;
            end else if (~|hist_q[i]) begin
                debounced_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            sync_q        <= {(CHANNELS*SYNC_STAGES){RESET_LEVEL}};
            hist_q        <= {(CHANNELS*FILTER_WIDTH){RESET_LEVEL}};
            debounced_q   <= {CHANNELS{RESET_LEVEL}};
            cnt_q         <= '0;
            sample_tick_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            hist_q        <= hist_d;
            debounced_q   <= debounced_d;
            cnt_q         <= cnt_d;
            sample_tick_q <= sample_tick_d;
        end
    end

    assign debounced   = debounced_q;
    assign sample_tick = sample_tick_q;

`ifdef DEBOUNCE_EDGE_EN
    logic [CHANNELS-1:0] rise_q, rise_d, fall_q, fall_d;

    // History resets to the same level as the output, so release never fakes an edge.
    always_comb begin
        rise_d = debounced_d & ~debounced_q;
        fall_d = ~debounced_d & debounced_q;
    end

    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Bench for multi_channel_debouncer: two instances (SAMPLE_DIV 1 and 4) against a sample-list model.
// Build with DEBOUNCE_EDGE_EN defined to also check rise/fall.
module tb_multi_channel_debouncer;
    localparam int CH    = 2;
    localparam int SS    = 2;
    localparam int FW    = 3;
    localparam int DIV_A = 1;
    localparam int DIV_B = 4;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          enable  = 1'b1;
    logic [CH-1:0] raw_in  = '0;
    logic [CH-1:0] db_a, db_b;
    logic          tick_a, tick_b;
`ifdef DEBOUNCE_EDGE_EN
    logic [CH-1:0] rise_a, fall_a, rise_b, fall_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_channel_debouncer #(.CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_WIDTH(FW),
                              .SAMPLE_DIV(DIV_A), .RESET_LEVEL(1'b1)) u_dut_a (
        .control_clock(clk), .reset(reset), .enable(enable), .raw_in(raw_in),
        .debounced(db_a), .sample_tick(tick_a)
`ifdef DEBOUNCE_EDGE_EN
        , .rise(rise_a), .fall(fall_a)
`endif
    );

    multi_channel_debouncer #(.CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_WIDTH(FW),
                              .SAMPLE_DIV(DIV_B), .RESET_LEVEL(1'b1)) u_dut_b (
        .control_clock(clk), .reset(reset), .enable(enable), .raw_in(raw_in),
        .debounced(db_b), .sample_tick(tick_b)
`ifdef DEBOUNCE_EDGE_EN
        , .rise(rise_b), .fall(fall_b)
`endif
    );

    // Model: raw delayed SS clocks, a list of the last FW samples taken on ticks,
    // output moves only when that list is unanimous.
    bit m_line [2][CH][SS];
    bit m_samp [2][CH][FW];
    bit m_out  [2][CH];
    bit m_rise [2][CH];
    bit m_fall [2][CH];
    int m_cnt  [2];
    bit m_tick [2];

    function automatic int div_of(int k);
        return (k == 0) ? DIV_A : DIV_B;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_tick[k] = 1'b0;
            for (int c = 0; c < CH; c++) begin
                for (int j = 0; j < SS; j++) m_line[k][c][j] = 1'b1;
                for (int j = 0; j < FW; j++) m_samp[k][c][j] = 1'b1;
                m_out[k][c]  = 1'b1;
                m_rise[k][c] = 1'b0;
                m_fall[k][c] = 1'b0;
            end
        end
    endtask

    task automatic model_step(int k);
        bit take;
        int ones;
        bit nxt;
        take = enable && (m_cnt[k] == div_of(k) - 1);
        for (int c = 0; c < CH; c++) begin
            ones = 0;
            for (int j = 0; j < FW; j++) ones += int'(m_samp[k][c][j]);
            nxt = (ones == FW) ? 1'b1 : (ones == 0) ? 1'b0 : m_out[k][c];
            if (take) begin
                for (int j = FW - 1; j > 0; j--) m_samp[k][c][j] = m_samp[k][c][j-1];
                m_samp[k][c][0] = m_line[k][c][SS-1];
            end
            for (int j = SS - 1; j > 0; j--) m_line[k][c][j] = m_line[k][c][j-1];
            m_line[k][c][0] = raw_in[c];
            m_rise[k][c] = nxt & ~m_out[k][c];
            m_fall[k][c] = ~nxt & m_out[k][c];
            m_out[k][c]  = nxt;
        end
        if (enable) m_cnt[k] = (m_cnt[k] + 1) % div_of(k);
        m_tick[k] = take;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(string name, int act, int lo, int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Compare process: every negedge, both instances against the model.
    initial begin
        logic [CH-1:0] e_db, e_r, e_f;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < CH; c++) begin
                    e_db[c] = m_out[k][c];
                    e_r[c]  = m_rise[k][c];
                    e_f[c]  = m_fall[k][c];
                end
                chk($sformatf("model_db%0d", k), (k == 0) ? db_a : db_b, e_db);
                chk($sformatf("model_tick%0d", k), (k == 0) ? tick_a : tick_b, m_tick[k]);
`ifdef DEBOUNCE_EDGE_EN
                chk($sformatf("model_rise%0d", k), (k == 0) ? rise_a : rise_b, e_r);
                chk($sformatf("model_fall%0d", k), (k == 0) ? fall_a : fall_b, e_f);
`endif
            end
        end
    end

    task automatic settle(logic [CH-1:0] v);
        raw_in = v;
        enable = 1'b1;
        repeat (25) @(negedge clk);
    endtask

    initial begin
        int n;
        int hold;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_db_a", db_a, 2'b11);
        chk("rst_db_b", db_b, 2'b11);
        chk("rst_tick_a", tick_a, 1'b0);

        // Release with raw low: A falls exactly 6 clocks later, B on clock 13.
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rel_hold5_a", db_a, 2'b11);
        @(negedge clk);
        chk("rel_fall6_a", db_a, 2'b00);
        repeat (6) @(negedge clk);
        chk("rel_hold12_b", db_b, 2'b11);
        @(negedge clk);
        chk("rel_fall13_b", db_b, 2'b00);

        // Two-clock glitch on channel 0 is rejected.
        settle(2'b11);
        raw_in = 2'b10;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 1) raw_in = 2'b11;
            chk("glitch_a", db_a, 2'b11);
            chk("glitch_b", db_b, 2'b11);
        end

        // Sustained low on channel 0: falls on clock 6 with a single fall pulse.
        raw_in = 2'b10;
        repeat (5) @(negedge clk);
        chk("ch0_hold5", db_a, 2'b11);
        @(negedge clk);
        chk("ch0_fall6", db_a, 2'b10);
`ifdef DEBOUNCE_EDGE_EN
        chk("ch0_fall_pulse", fall_a, 2'b01);
        @(negedge clk);
        chk("ch0_fall_done", fall_a, 2'b00);
`endif
        settle(2'b11);

        // SAMPLE_DIV=4 latency window for channel 1.
        raw_in = 2'b01;
        n = 0;
        while (db_b[1] && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk_range("div4_latency", n, 11, 15);
        chk("div4_ch0_steady", db_b[0], 1'b1);
        settle(2'b11);

        // Freeze mid-transition, then finish with the remaining samples.
        raw_in = 2'b00;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("freeze_hold", db_a, 2'b11);
        end
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("resume_hold2", db_a, 2'b11);
        @(negedge clk);
        chk("resume_fall3", db_a, 2'b00);
        settle(2'b00);

        // Async reset during a partial rise: outputs jump before the next edge.
        raw_in = 2'b11;
        repeat (3) @(negedge clk);
        chk("partial_pre", db_a, 2'b00);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_db_a", db_a, 2'b11);
        chk("async_db_b", db_b, 2'b11);
        chk("async_tick_a", tick_a, 1'b0);
`ifdef DEBOUNCE_EDGE_EN
        chk("async_rise_a", rise_a, 2'b00);
`endif
        @(negedge clk);
        raw_in = 2'b00;
        reset  = 1'b0;
        repeat (5) @(negedge clk);
        chk("rerel_hold5", db_a, 2'b11);
        @(negedge clk);
        chk("rerel_fall6", db_a, 2'b00);

        // Randomised traffic, checked by the compare process.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 9) != 0);
            if (hold > 0) begin
                hold--;
            end else if ($urandom_range(0, 99) < 5) begin
                hold = $urandom_range(10, 40);
            end else begin
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, 7) == 0) raw_in[c] = ~raw_in[c];
            end
        end

        settle(2'b11);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
